multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared single-port memory, register file, ALU and immediate generator.
- Drives the datapath mux selects and write enables, and holds on a memory ready handshake.
- Traps on illegal opcodes and on memory timeouts. Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).
- TIMEOUT, 16, max wait cycles per memory access before trap; 0 disables the timeout.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- opcode  input  7  IR[6:0], valid from DECODE onward
- branch_taken  input  1  branch comparison result from ALU, sampled in EXEC
- mem_ready  input  1  memory completes access this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  write strobe (store)
- mem_addr_sel  output  1  0=PC, 1=ALU result
- ir_write  output  1  load IR from memory read data
- pc_write  output  1  update PC
- pc_src  output  2  00=PC+4, 01=PC+imm, 10=ALU result & ~1
- alu_src_b  output  1  0=rs2, 1=imm
- alu_op  output  2  00=add, 01=funct-decoded (R/I), 10=compare (branch)
- reg_write  output  1  register file write enable
- wb_sel  output  2  00=ALU, 01=mem data, 10=PC+4, 11=imm
- trap  output  1  sticky; core halted
- trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout
- state_o  output  3  current state encoding (debug)
- retired  output  CNT_W  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset: state=FETCH, latched opcode=0, wait counter=0, retired=0, trap=0, trap_cause=00.
- Reset has priority over every event, including mid-access. The request drops the cycle after reset asserts.
- Outputs are combinational from the registered state, the latched opcode, mem_ready and branch_taken. All enables not listed for a state are 0.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1: ir_write=1 in that cycle, next state DECODE. Otherwise hold.
- DECODE, 1 cycle: latch opcode. Accepted opcodes: 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010011 ALU-I, 0110011 ALU-R. Any other value → TRAP with cause 01. Otherwise → EXEC.
- EXEC actions by opcode:
  - load/store: alu_src_b=1, alu_op=00; → MEM.
  - ALU-I: alu_src_b=1, alu_op=01; → WB.
  - ALU-R: alu_src_b=0, alu_op=01; → WB.
  - branch: alu_op=10, pc_write=1, pc_src = branch_taken ? 01 : 00; → FETCH.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01; → FETCH.
  - JALR: alu_src_b=1, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10; → FETCH.
  - LUI: reg_write=1, wb_sel=11, pc_write=1, pc_src=00; → FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store only.
  - Load with mem_ready → WB.
  - Store with mem_ready: pc_write=1, pc_src=00 in that cycle; → FETCH.
  - Without mem_ready: hold.
- WB: reg_write=1, wb_sel = 01 for load, 00 otherwise; pc_write=1, pc_src=00; → FETCH.
- Retire: retired increments on every cycle with pc_write=1. All-ones wraps to 0.
- Latency with zero-wait memory:
  - ALU-I/ALU-R: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch, JAL, JALR, LUI: 3 cycles.
  - Each wait cycle adds 1.
- Timeout (TIMEOUT≠0):
  - Wait counter clears on entry to FETCH or MEM and increments each cycle with mem_req=1 and mem_ready=0.
  - When the counter equals TIMEOUT and mem_ready=0 → TRAP with cause 10.
  - mem_ready in the same cycle wins: no trap.
- TRAP: all enables 0, trap=1, cause held. Exits only via reset.

Test Plan:
- Reset for 2 cycles, then release → state_o=0, mem_req=1, retired=0, trap=0, and no enables asserted during reset.
- ADDI (0010011), mem_ready tied 1 → states 0,1,2,4,0. reg_write and pc_write asserted only in WB with wb_sel=00 and pc_src=00; retired=1 after 4 cycles.
- Load, mem_ready low for 3 cycles in MEM → MEM held 4 cycles with mem_addr_sel=1 and mem_we=0. WB follows with wb_sel=01; total 8 cycles.
- Branch with branch_taken=1, then with branch_taken=0 → EXEC shows pc_src=01 then 00. Each instruction takes 3 cycles; retired increments by 2.
- Opcode 1111111 → TRAP entered in the cycle after DECODE: trap=1, trap_cause=01, state_o=7. Remains there 20 cycles until reset.
- TIMEOUT=4, store with mem_ready held 0 → TRAP after 5 MEM cycles (counter at 4) with trap_cause=10. Separately, assert reset mid-MEM → FETCH next cycle, mem_we=0, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb over a shared single-port memory.
// Latency 3-5 cycles per instruction plus memory wait cycles; holds on mem_ready, traps on illegal opcode or timeout.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cause_q <= 2'b00;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
        end
    end

    // mem_ready in the same cycle as the limit takes priority over the trap
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_MAX) && !mem_ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cause_d      = cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                    OP_JALR, OP_LUI, OP_ALUI, OP_ALUR: state_d = S_EXEC;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_ALUI: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'b01;
                        state_d   = S_WB;
                    end
                    OP_ALUR: begin
                        alu_op  = 2'b01;
                        state_d = S_WB;
                    end
                    OP_BRANCH: begin
                        alu_op   = 2'b10;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                        state_d   = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src_b = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b11;
                        pc_write  = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            wait_d = '0;
        end else if (TIMEOUT != 0 && mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign ret_d      = ret_q + {{(CNT_W-1){1'b0}}, pc_write};
    assign retired    = ret_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model queues per-cycle expectations, a monitor compares.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = '0;
    logic             branch_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]       pc_src, alu_op, wb_sel, trap_cause;
    logic             alu_src_b, reg_write, trap;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             req, we, asel, irw, pcw;
        logic [1:0]       pcs;
        logic             asb;
        logic [1:0]       aop;
        logic             rw;
        logic [1:0]       wbs;
        logic             trap;
        logic [1:0]       cause;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    model_ret = 0;
    int    cyc = 0;
    logic [6:0] legal_ops [0:7] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                                    OP_JALR, OP_LUI, OP_ALUI, OP_ALUR};

    // Monitor: one expectation per clock cycle, compared mid-cycle
    initial begin
        exp_t  e, act;
        string t;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {state_o, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                       alu_src_b, alu_op, reg_write, wb_sel, trap, trap_cause, retired};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %p expected %p", t, cyc, act, e);
                end
            end
        end
    end

    function automatic exp_t mk(input int st);
        exp_t e;
        e    = '0;
        e.st = 3'(st);
        return e;
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input logic rst, input logic rdy, input logic [6:0] op,
                         input logic bt, input exp_t e, input string tag);
        @(posedge clk);
        #1;
        reset        = rst;
        mem_ready    = rdy;
        opcode       = op;
        branch_taken = bt;
        e.ret        = CNT_W'(model_ret % (1 << CNT_W));
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (rst) model_ret = 0;
        else if (e.pcw) model_ret++;
    endtask

    // One instruction: wf fetch waits, wm memory waits; rst_mem = MEM cycle index carrying reset (-1 none).
    // Returns the trap cause the model predicts (0 = retired or reset normally).
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic bt,
                             input int rst_mem, output int tcause);
        exp_t e;
        logic rdy;
        bit   to_mem, to_wb;
        tcause = 0;
        for (int i = 0; i <= wf; i++) begin
            rdy = (i == wf);
            e = mk(0); e.req = 1'b1; e.irw = rdy;
            cycle(1'b0, rdy, junk(), 1'($urandom), e, "fetch");
            if (!rdy && i == TO) begin tcause = 2; return; end
        end
        e = mk(1);
        cycle(1'b0, 1'($urandom), op, 1'($urandom), e, "decode");
        if (!is_legal(op)) begin tcause = 1; return; end
        e = mk(2); to_mem = 0; to_wb = 0;
        case (op)
            OP_LOAD, OP_STORE: begin e.asb = 1; to_mem = 1; end
            OP_ALUI:   begin e.asb = 1; e.aop = 2'b01; to_wb = 1; end
            OP_ALUR:   begin e.aop = 2'b01; to_wb = 1; end
            OP_BRANCH: begin e.aop = 2'b10; e.pcw = 1; e.pcs = bt ? 2'b01 : 2'b00; end
            OP_JAL:    begin e.rw = 1; e.wbs = 2'b10; e.pcw = 1; e.pcs = 2'b01; end
            OP_JALR:   begin e.asb = 1; e.rw = 1; e.wbs = 2'b10; e.pcw = 1; e.pcs = 2'b10; end
            default:   begin e.rw = 1; e.wbs = 2'b11; e.pcw = 1; end
        endcase
        cycle(1'b0, 1'($urandom), junk(), bt, e, "exec");
        if (to_mem) begin
            for (int i = 0; i <= wm; i++) begin
                rdy = (i == wm);
                e = mk(3); e.req = 1; e.asel = 1; e.we = (op == OP_STORE);
                e.pcw = rdy && (op == OP_STORE);
                cycle(i == rst_mem, rdy, junk(), 1'($urandom), e, "mem");
                if (i == rst_mem) return;
                if (!rdy && i == TO) begin tcause = 2; return; end
            end
            to_wb = (op == OP_LOAD);
        end
        if (to_wb) begin
            e = mk(4); e.rw = 1; e.wbs = (op == OP_LOAD) ? 2'b01 : 2'b00; e.pcw = 1;
            cycle(1'b0, 1'($urandom), junk(), 1'($urandom), e, "wb");
        end
    endtask

    task automatic trap_then_reset(input int n, input int cause);
        exp_t e;
        e = mk(7); e.trap = 1; e.cause = 2'(cause);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), junk(), 1'($urandom), e, "trap_hold");
        cycle(1'b1, 1'b0, junk(), 1'b0, e, "trap_reset");
        e = mk(0); e.req = 1;
        cycle(1'b1, 1'b0, junk(), 1'b0, e, "reset_fetch");
    endtask

    task automatic random_instrs(input int n);
        int tc;
        for (int k = 0; k < n; k++) begin
            run_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, TO),
                      $urandom_range(0, TO), 1'($urandom), -1, tc);
            if (tc != 0) begin
                errors++;
                $display("FAIL random_instr %0d: model trap cause %0d, required 0", k, tc);
            end
        end
    endtask

    initial begin
        exp_t e;
        int   tc;
        e = mk(0); e.req = 1;
        cycle(1'b1, 1'b0, 7'd0, 1'b0, e, "reset");

        run_instr(OP_ALUI,   0, 0, 1'b0, -1, tc);
        run_instr(OP_LOAD,   0, 3, 1'b0, -1, tc);
        run_instr(OP_BRANCH, 0, 0, 1'b1, -1, tc);
        run_instr(OP_BRANCH, 0, 0, 1'b0, -1, tc);
        random_instrs(60);

        run_instr(7'b1111111, 0, 0, 1'b0, -1, tc);
        trap_then_reset(20, tc);

        run_instr(OP_STORE, 0, TO + 1, 1'b0, -1, tc);
        trap_then_reset(3, tc);

        run_instr(OP_ALUI, TO + 2, 0, 1'b0, -1, tc);
        trap_then_reset(2, tc);

        random_instrs(10);
        run_instr(OP_LOAD, 0, 3, 1'b0, 1, tc);
        run_instr(OP_STORE, 1, 2, 1'b0, -1, tc);
        random_instrs(40);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
